// File: rtl/demux1x4_phys_if.sv
// Byte-stream and lane bundle for the 1:4 receive demultiplexer.
// The sof alignment input exists only when DEMUX_ALIGN_EN is defined.
interface demux1x4_phys_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
`ifdef DEMUX_ALIGN_EN
  logic             sof;
`endif
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [3:0]       valid_out;
  logic             frame_stb;

`ifdef DEMUX_ALIGN_EN
  modport master (
    output data_in, valid_in, sof,
    input  out0, out1, out2, out3, valid_out, frame_stb
  );

  modport slave (
    input  data_in, valid_in, sof,
    output out0, out1, out2, out3, valid_out, frame_stb
  );
`else
  modport master (
    output data_in, valid_in,
    input  out0, out1, out2, out3, valid_out, frame_stb
  );

  modport slave (
    input  data_in, valid_in,
    output out0, out1, out2, out3, valid_out, frame_stb
  );
`endif
endinterface

// File: rtl/demux1x4_phys.sv
// 1:4 receive byte demultiplexer: one byte per clock over 4 slots, committed as a
// 4-lane word with per-lane valid every 4th clock. Optional sof alignment: DEMUX_ALIGN_EN.
module demux1x4_phys #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_DATA = '0
) (
  input  logic            clk,
  input  logic            reset,
  demux1x4_phys_if.slave  bus
);

  logic [1:0]       slot;
  logic [1:0]       cur_slot;
  logic [WIDTH-1:0] lane_buf [3];
  logic [2:0]       bvalid;
  logic             align;

`ifdef DEMUX_ALIGN_EN
  assign align = bus.sof;
`else
  assign align = 1'b0;
`endif

  // sof re-times the current cycle as slot 0, aborting any partially captured frame
  assign cur_slot = align ? 2'd0 : slot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot          <= 2'd0;
      lane_buf[0]   <= '0;
      lane_buf[1]   <= '0;
      lane_buf[2]   <= '0;
      bvalid        <= 3'b000;
      bus.out0      <= IDLE_DATA;
      bus.out1      <= IDLE_DATA;
      bus.out2      <= IDLE_DATA;
      bus.out3      <= IDLE_DATA;
      bus.valid_out <= 4'b0000;
      bus.frame_stb <= 1'b0;
    end else begin
      slot          <= cur_slot + 2'd1;
      bus.frame_stb <= 1'b0;
      case (cur_slot)
        2'd0: begin
          bvalid <= {2'b00, bus.valid_in};
          if (bus.valid_in) lane_buf[0] <= bus.data_in;
        end
        2'd1: begin
          bvalid[1] <= bus.valid_in;
          if (bus.valid_in) lane_buf[1] <= bus.data_in;
        end
        2'd2: begin
          bvalid[2] <= bus.valid_in;
          if (bus.valid_in) lane_buf[2] <= bus.data_in;
        end
        default: begin
          // The slot-3 byte goes straight to its lane so the word commits this edge
          bus.out0      <= bvalid[0] ? lane_buf[0] : IDLE_DATA;
          bus.out1      <= bvalid[1] ? lane_buf[1] : IDLE_DATA;
          bus.out2      <= bvalid[2] ? lane_buf[2] : IDLE_DATA;
          bus.out3      <= bus.valid_in ? bus.data_in : IDLE_DATA;
          bus.valid_out <= {bus.valid_in, bvalid};
          bus.frame_stb <= 1'b1;
          bvalid        <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux1x4_phys.sv
// Scoreboard bench for demux1x4_phys: a slot-level model queues each expected word
// when its slot-3 byte is driven; words are popped and compared on every frame_stb.
module tb_demux1x4_phys;

  typedef struct packed {
    logic [7:0] o0;
    logic [7:0] o1;
    logic [7:0] o2;
    logic [7:0] o3;
    logic [3:0] v;
  } frame_t;

`ifdef DEMUX_ALIGN_EN
  localparam bit ALIGN_BUILD = 1'b1;
`else
  localparam bit ALIGN_BUILD = 1'b0;
`endif

  logic clk;
  logic reset;

  demux1x4_phys_if #(.WIDTH(8)) bus ();

  demux1x4_phys #(.WIDTH(8), .IDLE_DATA(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  frame_t     exp_q[$];
  frame_t     held;
  int         m_slot;
  logic [7:0] m_buf [3];
  logic       m_bv  [3];
  logic       exp_stb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    held    = '0;
    m_slot  = 0;
    exp_stb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_buf[k] = 8'h00;
      m_bv[k]  = 1'b0;
    end
  endtask

  // Runs once per clock, 1 time unit after the rising edge
  task automatic sample_cycle();
    checkOutput("frame_stb", {31'd0, bus.frame_stb}, {31'd0, exp_stb});
    if (bus.frame_stb) begin
      if (exp_q.size() == 0) checkOutput("queue_pop", exp_q.size(), 1);
      else held = exp_q.pop_front();
    end
    checkOutput("out0", {24'd0, bus.out0}, {24'd0, held.o0});
    checkOutput("out1", {24'd0, bus.out1}, {24'd0, held.o1});
    checkOutput("out2", {24'd0, bus.out2}, {24'd0, held.o2});
    checkOutput("out3", {24'd0, bus.out3}, {24'd0, held.o3});
    checkOutput("valid_out", {28'd0, bus.valid_out}, {28'd0, held.v});
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic s);
    int     eff;
    frame_t f;
    bus.valid_in = v;
    bus.data_in  = d;
`ifdef DEMUX_ALIGN_EN
    bus.sof = s;
`endif
    eff = (s && ALIGN_BUILD) ? 0 : m_slot;
    if (eff == 3) begin
      f.o0 = m_bv[0] ? m_buf[0] : 8'h00;
      f.o1 = m_bv[1] ? m_buf[1] : 8'h00;
      f.o2 = m_bv[2] ? m_buf[2] : 8'h00;
      f.o3 = v ? d : 8'h00;
      f.v  = {v, m_bv[2], m_bv[1], m_bv[0]};
      exp_q.push_back(f);
      exp_stb = 1'b1;
      for (int k = 0; k < 3; k++) m_bv[k] = 1'b0;
    end else begin
      exp_stb = 1'b0;
      if (eff == 0) begin
        m_bv[1] = 1'b0;
        m_bv[2] = 1'b0;
      end
      if (v) m_buf[eff] = d;
      m_bv[eff] = v;
    end
    m_slot = (eff + 1) % 4;
    @(posedge clk);
    #1;
    sample_cycle();
  endtask

  task automatic apply_frame(input logic [3:0] v, input logic [31:0] bytes);
    for (int k = 0; k < 4; k++) applyStimulus(v[k], bytes[8*k +: 8], 1'b0);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock
  task automatic reset_mid_run();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_out0", {24'd0, bus.out0}, 32'h00);
    checkOutput("rst_async_out3", {24'd0, bus.out3}, 32'h00);
    checkOutput("rst_async_valid", {28'd0, bus.valid_out}, 32'h0);
    checkOutput("rst_async_stb", {31'd0, bus.frame_stb}, 32'h0);
    model_clear();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_hold_stb", {31'd0, bus.frame_stb}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
`ifdef DEMUX_ALIGN_EN
    bus.sof = 1'b0;
`endif
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_out0", {24'd0, bus.out0}, 32'h00);
    checkOutput("rst_out2", {24'd0, bus.out2}, 32'h00);
    checkOutput("rst_valid", {28'd0, bus.valid_out}, 32'h0);
    checkOutput("rst_stb", {31'd0, bus.frame_stb}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] full frame");
    apply_frame(4'b1111, 32'hD3C2B1A0);
    checkOutput("full_out0", {24'd0, bus.out0}, 32'hA0);
    checkOutput("full_out1", {24'd0, bus.out1}, 32'hB1);
    checkOutput("full_out2", {24'd0, bus.out2}, 32'hC2);
    checkOutput("full_out3", {24'd0, bus.out3}, 32'hD3);
    checkOutput("full_valid", {28'd0, bus.valid_out}, 32'hF);
    checkOutput("full_stb", {31'd0, bus.frame_stb}, 32'h1);

    $display("[TB] partial frame");
    apply_frame(4'b1010, 32'hAA_EE_55_99);
    checkOutput("part_out0", {24'd0, bus.out0}, 32'h00);
    checkOutput("part_out1", {24'd0, bus.out1}, 32'h55);
    checkOutput("part_out2", {24'd0, bus.out2}, 32'h00);
    checkOutput("part_out3", {24'd0, bus.out3}, 32'hAA);
    checkOutput("part_valid", {28'd0, bus.valid_out}, 32'hA);

    $display("[TB] all-invalid frame");
    apply_frame(4'b0000, 32'h12345678);
    checkOutput("empty_valid", {28'd0, bus.valid_out}, 32'h0);
    checkOutput("empty_stb", {31'd0, bus.frame_stb}, 32'h1);

    $display("[TB] back-to-back frames");
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'(i + 1), 1'b0);
    checkOutput("b2b_out0", {24'd0, bus.out0}, 32'h09);
    checkOutput("b2b_out1", {24'd0, bus.out1}, 32'h0A);
    checkOutput("b2b_out2", {24'd0, bus.out2}, 32'h0B);
    checkOutput("b2b_out3", {24'd0, bus.out3}, 32'h0C);

    $display("[TB] random frames");
    for (int i = 0; i < 16; i++) applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    reset_mid_run();
    apply_frame(4'b1100, 32'h44_33_00_00);
    checkOutput("abort_out0", {24'd0, bus.out0}, 32'h00);
    checkOutput("abort_out1", {24'd0, bus.out1}, 32'h00);
    checkOutput("abort_out2", {24'd0, bus.out2}, 32'h33);
    checkOutput("abort_valid", {28'd0, bus.valid_out}, 32'hC);

`ifdef DEMUX_ALIGN_EN
    $display("[TB] sof realignment");
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1);
    applyStimulus(1'b1, 8'h88, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0);
    applyStimulus(1'b1, 8'hAB, 1'b0);
    checkOutput("sof_out0", {24'd0, bus.out0}, 32'h77);
    checkOutput("sof_valid", {28'd0, bus.valid_out}, 32'hF);
    applyStimulus(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    checkOutput("sof_slot0_out0", {24'd0, bus.out0}, 32'h5A);
`endif

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
